// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/capture pair: FSM encoding and counter limits.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  // Largest count a width-bit counter can hold (2^width - 1).
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'(1) << width) - 32'(1);
  endfunction

endpackage

// File: rtl/sincronizador_flancos.sv
// Two-flop synchronizer for an asynchronous level plus a delay stage for edge detection.
module sincronizador_flancos (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic s2,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = pwm_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign s2   = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time (rise to fall) of a PWM input in clk cycles.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(cnt_max(WIDTH));
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic s2, rise, fall;

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;

  sincronizador_flancos u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .s2     (s2),
    .rise   (rise),
    .fall   (fall)
  );

  // Next-state, counters and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    period_d   = period_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    overflow_d = overflow_q;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          hcnt_d = '0;
          if (rise) begin
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
            state_d = ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (fall) begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = ST_LOW;
          end else if (cnt_q == CNT_MAX) begin
            overflow_d = 1'b1;
            cnt_d      = '0;
            hcnt_d     = '0;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            // Without a fall the synchronized level is still high here.
            if (s2) hcnt_d = hcnt_q + CNT_ONE;
          end
        end

        ST_LOW: begin
          if (rise) begin
            period_d   = cnt_q;
            duty_d     = hcnt_q;
            valid_d    = 1'b1;
            overflow_d = 1'b0;
            cnt_d      = CNT_ONE;
            hcnt_d     = CNT_ONE;
            state_d    = ST_HIGH;
          end else if (cnt_q == CNT_MAX) begin
            overflow_d = 1'b1;
            cnt_d      = '0;
            hcnt_d     = '0;
            state_d    = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      period_q   <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      period_q   <= period_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign period_out = period_q;
  assign duty_out   = duty_q;
  assign valid      = valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: steady PWM, loopback generator, stuck input, reset, enable.
module tb_pwm_capture;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pwm_in;
  logic [7:0] period_out;
  logic [7:0] duty_out;
  logic       valid;
  logic       overflow;

  logic pwm_drv;
  logic gen_en;
  int   gcnt;
  logic gen_out;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int last_t = 0;
  int prev_t = 0;
  logic valid_prev = 1'b0;

  pwm_capture #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .duty_out   (duty_out),
    .valid      (valid),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator: period 20, high 7.
  always @(posedge clk) begin
    if (!gen_en) gcnt <= 0;
    else         gcnt <= (gcnt == 19) ? 0 : gcnt + 1;
  end
  assign gen_out = gen_en && (gcnt < 7);
  assign pwm_in  = gen_en ? gen_out : pwm_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count valid pulses and their spacing; a pulse must never last two cycles.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (valid) begin
      chk("valid_one_cycle", 32'(valid_prev), 32'd0);
      prev_t = last_t;
      last_t = cyc;
      valid_cnt++;
    end
    valid_prev = valid;
  end

  task automatic drive(input logic v, input int n);
    pwm_drv = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < max_cycles);
    chk(tag, 32'(valid), 32'd1);
  endtask

  int vc0;

  initial begin
    reset   = 1'b1;
    enable  = 1'b1;
    pwm_drv = 1'b0;
    gen_en  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", 32'(period_out), 32'd0);
    chk("rst_duty", 32'(duty_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    drive(1'b0, 4);

    // Steady 10/4: first rise arms only.
    drive(1'b1, 4);
    drive(1'b0, 6);
    chk("steady_arm_no_valid", 32'(valid_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 6);
    end
    chk("steady_valid_count", 32'(valid_cnt), 32'd4);
    chk("steady_period", 32'(period_out), 32'd10);
    chk("steady_duty", 32'(duty_out), 32'd4);
    chk("steady_overflow", 32'(overflow), 32'd0);
    chk("steady_spacing", 32'(last_t - prev_t), 32'd10);

    // Loopback generator; its first rise closes the last steady period.
    gen_en = 1'b1;
    wait_valid(20, "gen_first_valid");
    chk("gen_first_period", 32'(period_out), 32'd10);
    chk("gen_first_duty", 32'(duty_out), 32'd4);
    for (int i = 0; i < 5; i++) begin
      wait_valid(25, "gen_valid");
      chk("gen_period", 32'(period_out), 32'd20);
      chk("gen_duty", 32'(duty_out), 32'd7);
    end
    chk("gen_spacing", 32'(last_t - prev_t), 32'd20);

    // Stuck low after an armed rise.
    pwm_drv = 1'b0;
    gen_en  = 1'b0;
    vc0 = valid_cnt;
    drive(1'b0, 300);
    chk("stuck_low_overflow", 32'(overflow), 32'd1);
    chk("stuck_low_no_valid", 32'(valid_cnt), 32'(vc0));
    chk("stuck_low_period_held", 32'(period_out), 32'd20);
    chk("stuck_low_duty_held", 32'(duty_out), 32'd7);
    drive(1'b1, 6);
    drive(1'b0, 6);
    chk("recover_arm_no_valid", 32'(valid_cnt), 32'(vc0));
    chk("recover_overflow_sticky", 32'(overflow), 32'd1);
    pwm_drv = 1'b1;
    wait_valid(10, "recover_valid");
    chk("recover_period", 32'(period_out), 32'd12);
    chk("recover_duty", 32'(duty_out), 32'd6);
    chk("recover_overflow_clear", 32'(overflow), 32'd0);

    // 100% duty.
    vc0 = valid_cnt;
    drive(1'b1, 300);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_no_valid", 32'(valid_cnt), 32'(vc0));
    chk("full_period_held", 32'(period_out), 32'd12);
    chk("full_duty_held", 32'(duty_out), 32'd6);

    // Reset while in HIGH.
    drive(1'b0, 5);
    drive(1'b1, 3);
    pwm_drv = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    chk("midrst_period", 32'(period_out), 32'd0);
    chk("midrst_duty", 32'(duty_out), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    drive(1'b0, 8);
    vc0 = valid_cnt;
    drive(1'b1, 5);
    drive(1'b0, 5);
    chk("midrst_arm_no_valid", 32'(valid_cnt), 32'(vc0));
    pwm_drv = 1'b1;
    wait_valid(10, "midrst_valid");
    chk("midrst_new_period", 32'(period_out), 32'd10);
    chk("midrst_new_duty", 32'(duty_out), 32'd5);
    drive(1'b1, 2);
    drive(1'b0, 5);

    // Enable dropped for 30 cycles mid-stream.
    drive(1'b1, 5);
    drive(1'b0, 5);
    enable = 1'b0;
    vc0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5);
      drive(1'b0, 5);
    end
    chk("dis_no_valid", 32'(valid_cnt), 32'(vc0));
    chk("dis_period_held", 32'(period_out), 32'd10);
    chk("dis_duty_held", 32'(duty_out), 32'd5);
    enable = 1'b1;
    drive(1'b1, 4);
    drive(1'b0, 6);
    chk("reen_arm_no_valid", 32'(valid_cnt), 32'(vc0));
    pwm_drv = 1'b1;
    wait_valid(10, "reen_valid");
    chk("reen_period", 32'(period_out), 32'd10);
    chk("reen_duty", 32'(duty_out), 32'd4);
    chk("reen_overflow", 32'(overflow), 32'd0);
    drive(1'b1, 2);
    drive(1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
